// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg
// Shared definitions for the parametrised asynchronous-SRAM controller:
//   - state encodings (plain localparams so older tools can consume them)
//   - request direction codes carried on req_rw
//   - helper that sizes the shared wait counter from the timing parameters
package sram_ctrl_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD_ACT   = 3'd1;
  localparam logic [2:0] ST_WR_SETUP = 3'd2;
  localparam logic [2:0] ST_WR_PULSE = 3'd3;
  localparam logic [2:0] ST_WR_HOLD  = 3'd4;
  localparam logic [2:0] ST_TURN     = 3'd5;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // The counter is loaded with (cycles - 1), so it must hold the largest
  // cycle count; never narrower than one bit.
  function automatic int cnt_width(input int rd, input int wr, input int ta);
    int m;
    m = max3(rd, wr, ta);
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// sram_wait_cnt
// Loadable down-counter with a zero flag. One instance times every timed
// controller state (read strobe, write pulse, turnaround).
// Ports:
//   clk       in  system clock
//   rst_n     in  asynchronous active-low reset
//   load      in  load load_val on this edge (takes priority over counting)
//   load_val  in  value loaded; the state lasts load_val + 1 cycles
//   zero      out count has reached zero
module sram_wait_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Count down to zero and park there until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sram_ctrl_param.sv
// sram_ctrl_param
// Single-port controller for an asynchronous SRAM with a valid/ready request
// side, programmable read/write strobe lengths, write setup/hold cycles and
// bus turnaround cycles.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake; ready only while idle
//   req_rw                 1 = read, 0 = write
//   req_addr/req_wdata     request address / write data (captured at accept)
//   rsp_valid              1-cycle pulse when rsp_rdata has been updated
//   rsp_rdata              last read data, held until the next read completes
//   wr_done                1-cycle pulse when a write cycle has finished
//   busy                   controller is not idle
//   sram_addr              registered SRAM address
//   sram_ce_n/oe_n/we_n    registered active-low SRAM strobes
//   sram_dq                SRAM data bus, driven only during write states
module sram_ctrl_param
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 8,
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 2,
  parameter int TA_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              wr_done,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  inout  wire  [DATA_W-1:0] sram_dq
);

  localparam int CNT_W = cnt_width(RD_CYCLES, WR_CYCLES, TA_CYCLES);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TA_LOAD = CNT_W'((TA_CYCLES > 0) ? TA_CYCLES - 1 : 0);
  // With no turnaround the op finishes straight into IDLE.
  localparam logic [2:0] POST_OP = (TA_CYCLES > 0) ? ST_TURN : ST_IDLE;
  localparam logic       POST_OP_LOAD = (TA_CYCLES > 0);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_zero;
  logic [DATA_W-1:0] wdata_q;
  logic              dq_oe;
  logic              accept;

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign accept    = req_valid && req_ready;

  sram_wait_cnt #(
    .CNT_W(CNT_W)
  ) u_wait_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (cnt_load),
    .load_val(cnt_val),
    .zero    (cnt_zero)
  );

  // Next-state logic. The counter is loaded on the edge that enters a timed
  // state and the state is left on the edge where the counter reads zero.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          case (req_rw)
            RW_READ: begin
              state_nxt = ST_RD_ACT;
              cnt_load  = 1'b1;
              cnt_val   = RD_LOAD;
            end
            RW_WRITE: begin
              state_nxt = ST_WR_SETUP;
            end
          endcase
        end
      end
      ST_RD_ACT: begin
        if (cnt_zero) begin
          state_nxt = POST_OP;
          cnt_load  = POST_OP_LOAD;
          cnt_val   = TA_LOAD;
        end
      end
      ST_WR_SETUP: begin
        state_nxt = ST_WR_PULSE;
        cnt_load  = 1'b1;
        cnt_val   = WR_LOAD;
      end
      ST_WR_PULSE: begin
        if (cnt_zero) begin
          state_nxt = ST_WR_HOLD;
        end
      end
      ST_WR_HOLD: begin
        state_nxt = POST_OP;
        cnt_load  = POST_OP_LOAD;
        cnt_val   = TA_LOAD;
      end
      ST_TURN: begin
        if (cnt_zero) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register plus request capture. Address and write data are only
  // sampled at accept so later changes on the request bus are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sram_addr <= '0;
      wdata_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sram_addr <= req_addr;
        wdata_q   <= req_wdata;
      end
    end
  end

  // Strobes and the pad enable are decoded from the next state and
  // registered, so every pin changes exactly on a clock edge and the
  // read/write phases never overlap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      dq_oe     <= 1'b0;
    end else begin
      sram_ce_n <= !((state_nxt == ST_RD_ACT)   || (state_nxt == ST_WR_SETUP) ||
                     (state_nxt == ST_WR_PULSE) || (state_nxt == ST_WR_HOLD));
      sram_oe_n <= (state_nxt != ST_RD_ACT);
      sram_we_n <= (state_nxt != ST_WR_PULSE);
      dq_oe     <= (state_nxt == ST_WR_SETUP) || (state_nxt == ST_WR_PULSE) ||
                   (state_nxt == ST_WR_HOLD);
    end
  end

  // Completion pulses. Read data is sampled on the final read-strobe edge,
  // while oe_n is still low, and the pulses appear in the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      wr_done   <= 1'b0;
    end else begin
      rsp_valid <= (state == ST_RD_ACT) && cnt_zero;
      wr_done   <= (state == ST_WR_HOLD);
      if ((state == ST_RD_ACT) && cnt_zero) begin
        rsp_rdata <= sram_dq;
      end
    end
  end

  assign sram_dq = dq_oe ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_ctrl_param.sv
// tb_sram_ctrl_param
// Self-checking bench: an asynchronous SRAM model on the pins, a cycle-level
// timeline model of the request side (occupancy, pulse timing, read data
// from a reference memory) checked every cycle, directed scenarios with
// literal expectations and a randomized mixed read/write run. A second
// instance with a 16-bit bus and different timing is driven for the
// alternate parameter set.
module tb_sram_ctrl_param;

  localparam int RD = 2;
  localparam int WR = 2;
  localparam int TA = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_valid16 = 1'b0;
  logic        req_rw = 1'b0;
  logic [18:0] req_addr = '0;
  logic [15:0] req_wdata = '0;

  logic        req_ready, rsp_valid, wr_done, busy;
  logic [7:0]  rsp_rdata;
  logic [18:0] sram_addr;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  wire  [7:0]  sram_dq;

  logic        ready16, rsp16, wd16, busy16;
  logic [15:0] rdata16;
  logic [7:0]  addr16;
  logic        ce16_n, oe16_n, we16_n;
  wire  [15:0] dq16;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sram_ctrl_param #(
    .ADDR_W(19), .DATA_W(8), .RD_CYCLES(RD), .WR_CYCLES(WR), .TA_CYCLES(TA)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata[7:0]),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .wr_done(wr_done), .busy(busy),
    .sram_addr(sram_addr), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_dq(sram_dq)
  );

  sram_ctrl_param #(
    .ADDR_W(8), .DATA_W(16), .RD_CYCLES(3), .WR_CYCLES(1), .TA_CYCLES(0)
  ) dut16 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid16), .req_ready(ready16),
    .req_rw(req_rw), .req_addr(req_addr[7:0]), .req_wdata(req_wdata),
    .rsp_valid(rsp16), .rsp_rdata(rdata16), .wr_done(wd16), .busy(busy16),
    .sram_addr(addr16), .sram_ce_n(ce16_n), .sram_oe_n(oe16_n),
    .sram_we_n(we16_n), .sram_dq(dq16)
  );

  wire        obs_ready = sel ? ready16 : req_ready;
  wire        obs_pulse = sel ? (rsp16 | wd16) : (rsp_valid | wr_done);
  wire [15:0] obs_rdata = sel ? rdata16 : {8'h00, rsp_rdata};

  // Asynchronous SRAM models: drive the bus while CE and OE are low and WE
  // is high; a write is committed when WE rises with CE still low.
  logic [7:0]  sram_mem [0:524287];
  logic [15:0] mem16 [0:255];
  assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? sram_mem[sram_addr] : 8'bz;
  assign dq16    = (!ce16_n && !oe16_n && we16_n) ? mem16[addr16] : 16'bz;

  logic        prev16;
  logic [15:0] latch16;
  initial begin
    for (int i = 0; i < 524288; i++) sram_mem[i] = 8'h00;
    for (int i = 0; i < 256; i++) mem16[i] = 16'h0000;
    prev16 = 1'b1;
    latch16 = '0;
    forever begin
      @(negedge clk);
      if (!we16_n) latch16 = dq16;
      else if (!prev16 && !ce16_n) mem16[addr16] = latch16;
      prev16 = we16_n;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic failNow(input string name);
    n_checks++;
    $display("[TB] FAIL %s: bound of cycles expired, required event never seen", name);
  endtask

  // Reference model of the request side: who is accepted when, when each
  // pulse is due and what read data must come back.
  logic [7:0]  ref_mem [int];
  int          e = 0;
  int          ready_from = 0;
  int          rsp_at = -1;
  int          wd_at = -1;
  logic [7:0]  held = 8'h00;
  logic [7:0]  rsp_data = 8'h00;
  logic [18:0] cur_addr = '0;
  logic [7:0]  cur_wdata = '0;
  logic        pend_wr = 1'b0;
  logic [18:0] pend_addr = '0;
  logic [7:0]  pend_data = '0;

  function automatic logic [7:0] ref_rd(input logic [18:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        ready_from = 0; rsp_at = -1; wd_at = -1; held = 8'h00; pend_wr = 1'b0;
      end else begin
        e++;
        if (pend_wr && e == wd_at) begin
          ref_mem[int'(pend_addr)] = pend_data;
          pend_wr = 1'b0;
        end
        if (e == rsp_at) held = rsp_data;
        if (req_valid && (e - 1 >= ready_from)) begin
          cur_addr  = req_addr;
          cur_wdata = req_wdata[7:0];
          if (req_rw) begin
            rsp_at = e + RD;
            rsp_data = ref_rd(req_addr);
            ready_from = e + RD + TA;
          end else begin
            wd_at = e + WR + 2;
            pend_wr = 1'b1;
            pend_addr = req_addr;
            pend_data = req_wdata[7:0];
            ready_from = e + WR + 2 + TA;
          end
        end
      end
    end
  end

  // Per-cycle comparison of the main instance against the model, plus the
  // SRAM-side timing and bus-ownership checks.
  logic       prev_we = 1'b1;
  int         we_low = 0;
  int         oe_low = 0;
  int         last_oe_low = 0;
  logic [7:0] wr_latch = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        checkOutput("rst_ce_n", 32'(sram_ce_n), 1);
        checkOutput("rst_oe_n", 32'(sram_oe_n), 1);
        checkOutput("rst_we_n", 32'(sram_we_n), 1);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("rst_wr_done", 32'(wr_done), 0);
        checkOutput("rst_rdata", 32'(rsp_rdata), 0);
        checkOutput("rst_addr", 32'(sram_addr), 0);
        prev_we = 1'b1; we_low = 0; oe_low = 0;
      end else begin
        checkOutput("req_ready", 32'(req_ready), 32'(e >= ready_from));
        checkOutput("busy", 32'(busy), 32'(e < ready_from));
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(e == rsp_at));
        checkOutput("wr_done", 32'(wr_done), 32'(e == wd_at));
        checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(held));
        checkOutput("oe_we_overlap", 32'(!sram_oe_n && !sram_we_n), 0);
        if (!sram_we_n) checkOutput("we_without_ce", 32'(sram_ce_n), 0);
        if (!sram_ce_n) checkOutput("sram_addr", 32'(sram_addr), 32'(cur_addr));
        if (!sram_we_n) begin
          we_low++;
          checkOutput("wr_dq", 32'(sram_dq), 32'(cur_wdata));
          wr_latch = sram_dq;
        end else if (!prev_we) begin
          if (!sram_ce_n) begin
            checkOutput("tWP", 32'(we_low), RD == RD ? WR : WR);
            sram_mem[sram_addr] = wr_latch;
          end
          we_low = 0;
        end
        prev_we = sram_we_n;
        if (!sram_oe_n) begin
          oe_low++;
          checkOutput("rd_dq_contention", 32'(sram_dq), 32'(sram_mem[sram_addr]));
        end else if (oe_low != 0) begin
          checkOutput("tOE", 32'(oe_low), RD);
          last_oe_low = oe_low;
          oe_low = 0;
        end
      end
    end
  end

  // Presents one request on the selected instance and follows it to the
  // cycle req_ready returns. pe/re are cycles after the accept edge at which
  // the completion pulse and req_ready were seen. With hold, req_valid stays
  // high and the request fields are scrambled while the op is in flight.
  task automatic applyStimulus(input logic rw, input logic [18:0] addr, input logic [15:0] wd,
                               input bit hold, output int pe, output int re);
    int t;
    pe = -1; re = -1; t = 0;
    req_rw = rw; req_addr = addr; req_wdata = wd;
    if (sel) req_valid16 = 1'b1; else req_valid = 1'b1;
    while (!obs_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!obs_ready) begin
      failNow("accept_timeout");
      req_valid = 1'b0; req_valid16 = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (hold) begin
      req_rw = 1'($urandom); req_addr = 19'($urandom); req_wdata = 16'($urandom);
    end else begin
      req_valid = 1'b0; req_valid16 = 1'b0;
    end
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (obs_pulse && pe < 0) pe = k;
      if (obs_ready) begin
        re = k;
        break;
      end
    end
    if (re < 0) failNow("ready_timeout");
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int pe, re;
    logic [18:0] a;

    repeat (3) @(negedge clk);
    checkOutput("t1_reset_busy", 32'(busy), 0);
    checkOutput("t1_reset_we_n", 32'(sram_we_n), 1);
    #1 rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] write 0x00010 <- 0xA5");
    applyStimulus(1'b0, 19'h00010, 16'h00A5, 1'b0, pe, re);
    checkOutput("t1_wr_done_edge", 32'(pe), 4);
    checkOutput("t1_ready_edge", 32'(re), 5);

    $display("[TB] read 0x00010");
    applyStimulus(1'b1, 19'h00010, 16'h0000, 1'b0, pe, re);
    checkOutput("t2_rsp_edge", 32'(pe), 2);
    checkOutput("t2_ready_edge", 32'(re), 3);
    checkOutput("t2_rdata", 32'(rsp_rdata), 32'hA5);
    checkOutput("t2_oe_low_cycles", 32'(last_oe_low), 2);

    $display("[TB] back-to-back write/read 0x7FFFF");
    applyStimulus(1'b0, 19'h7FFFF, 16'h003C, 1'b1, pe, re);
    checkOutput("t3_wr_done_edge", 32'(pe), 4);
    applyStimulus(1'b1, 19'h7FFFF, 16'h0000, 1'b0, pe, re);
    checkOutput("t3_rsp_edge", 32'(pe), 2);
    checkOutput("t3_rdata", 32'(rsp_rdata), 32'h3C);

    $display("[TB] reset during write pulse");
    req_rw = 1'b0; req_addr = 19'h00010; req_wdata = 16'h005A; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("t4_mid_pulse_we_n", 32'(sram_we_n), 0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t4_abort_we_n", 32'(sram_we_n), 1);
    checkOutput("t4_abort_ce_n", 32'(sram_ce_n), 1);
    checkOutput("t4_abort_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 19'h00010, 16'h0000, 1'b0, pe, re);
    checkOutput("t4_read_after_abort", 32'(rsp_rdata), 32'hA5);

    $display("[TB] 16-bit instance, RD=3 WR=1 TA=0");
    sel = 1'b1;
    applyStimulus(1'b0, 19'h00021, 16'hBEEF, 1'b0, pe, re);
    checkOutput("t5_wr_done_edge", 32'(pe), 3);
    checkOutput("t5_wr_ready_edge", 32'(re), 3);
    applyStimulus(1'b1, 19'h00021, 16'h0000, 1'b0, pe, re);
    checkOutput("t5_rsp_edge", 32'(pe), 3);
    checkOutput("t5_rd_ready_edge", 32'(re), 3);
    checkOutput("t5_rdata", 32'(obs_rdata), 32'hBEEF);
    checkOutput("t5_busy_after", 32'(busy16), 0);
    sel = 1'b0;

    $display("[TB] random mixed traffic");
    for (int i = 0; i < 4000; i++) begin
      bit hold;
      a = ($urandom_range(0, 1) == 1) ? 19'($urandom_range(0, 63))
                                      : 19'h7FFFF - 19'($urandom_range(0, 63));
      hold = ($urandom_range(0, 1) == 1);
      applyStimulus(1'($urandom), a, 16'($urandom), hold, pe, re);
      if (!hold && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    req_valid = 1'b0;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
